// File: rtl/cpu_io_pkg.sv
// Shared types and default parameter values for the CPU I/O port bank.
package cpu_io_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } io_state_e;

  localparam logic [7:0] DEF_BASE_ADDR  = 8'h98;
  localparam int         DEF_PORT_BITS  = 2;
  localparam int         DEF_FILTER_LEN = 3;
  localparam int         DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/io_strobe_filter.sv
// Registers a qualified strobe and only moves the filtered level after
// FILTER_LEN consecutive identical registered samples.
module io_strobe_filter
  import cpu_io_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(FILTER_LEN);

  logic             sample_q, sample_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sample_d = din;
    level_d  = level_q;
    cnt_d    = '0;
    if (sample_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sample_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sample_q <= sample_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/cpu_io_port_bank.sv
// CPU I/O port window: address decode, read-back bus drive, filtered strobes
// and a small queue of captured accesses handed to the core.
module cpu_io_port_bank
  import cpu_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int         PORT_BITS  = DEF_PORT_BITS,
  parameter int         FILTER_LEN = DEF_FILTER_LEN,
  parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           A,
  inout  wire  [7:0]           cd,
  input  logic                 rd_iorq_n,
  input  logic                 wr_iorq_n,
  input  logic [7:0]           rd_data,
  output logic                 cs_n,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic                 req_wr,
  output logic [PORT_BITS-1:0] req_port,
  output logic [7:0]           req_data,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int ENTRY_W = 1 + PORT_BITS + 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic match, rd_qual, wr_qual;

  assign match   = (A[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]);
  assign rd_qual = match & ~rd_iorq_n;
  assign wr_qual = match & ~wr_iorq_n;
  assign cs_n    = ~(rd_qual | wr_qual);
  assign cd      = rd_qual ? rd_data : 8'hzz;

  logic rd_filt, wr_filt;

  io_strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filter (
    .clk   (clk),
    .reset (reset),
    .din   (rd_qual),
    .dout  (rd_filt)
  );

  io_strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filter (
    .clk   (clk),
    .reset (reset),
    .din   (wr_qual),
    .dout  (wr_filt)
  );

  logic [PORT_BITS-1:0] port_q, port_d;
  logic [7:0]           data_q, data_d;
  io_state_e            state_q, state_d;
  logic                 push, both_set;
  logic [ENTRY_W-1:0]   push_entry;

  assign port_d     = A[PORT_BITS-1:0];
  assign data_d     = cd;
  assign push_entry = {wr_filt, port_q, (wr_filt ? data_q : 8'h00)};

  // One capture per access: the first filtered strobe opens it, both low closes it.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    both_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_filt && wr_filt) begin
          state_d  = ACTIVE;
          both_set = 1'b1;
        end else if (rd_filt || wr_filt) begin
          state_d = ACTIVE;
          push    = 1'b1;
        end
      end
      ACTIVE: begin
        if (!rd_filt && !wr_filt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full, pop, push_ok, ovf_set;
  logic [ENTRY_W-1:0] head;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = req_valid & req_ready;
  assign push_ok = push & (~full | pop);
  assign ovf_set = both_set | (push & full & ~pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q     <= '0;
      data_q     <= '0;
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      port_q     <= port_d;
      data_q     <= data_d;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: queue storage is left out of reset; the head is masked by req_valid so stale contents never reach the core.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign req_valid = (count_q != '0);
  assign {req_wr, req_port, req_data} = req_valid ? head : '0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_io_port_bank.sv
// Self-checking bench: directed scenarios plus randomized accesses compared
// every cycle against a behavioural model of the port bank.
module tb_cpu_io_port_bank;

  localparam logic [7:0] BASE  = 8'h98;
  localparam int         PB    = 2;
  localparam int         FL    = 3;
  localparam int         DEPTH = 4;

  logic          clk, rst;
  logic [7:0]    A, rd_data, tb_cd;
  logic          rd_n, wr_n, req_ready, ovf_clr;
  wire  [7:0]    cd;
  logic          tb_cd_oe;
  logic          cs_n, req_valid, req_wr, overflow;
  logic [PB-1:0] req_port;
  logic [7:0]    req_data;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  rnd_mode = 0;

  assign tb_cd_oe = rd_n;
  assign cd = tb_cd_oe ? tb_cd : 8'hzz;

  cpu_io_port_bank #(
    .BASE_ADDR(BASE), .PORT_BITS(PB), .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(rst), .A(A), .cd(cd), .rd_iorq_n(rd_n), .wr_iorq_n(wr_n),
    .rd_data(rd_data), .cs_n(cs_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_port(req_port), .req_data(req_data),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { bit wr; int port; int data; } entry_t;
  entry_t mq[$];
  bit     m_rs, m_ws, m_rf, m_wf, m_active, m_ovf;
  bit     r_val, w_val;
  int     r_len, w_len;
  int     m_port, m_cd;

  function automatic bit in_window(logic [7:0] a);
    return (a >> PB) == (BASE >> PB);
  endfunction

  always @(posedge clk) begin
    bit     old_rf, old_wf, pop, push, set;
    entry_t e;
    if (rst) begin
      mq.delete();
      {m_rs, m_ws, m_rf, m_wf, m_active, m_ovf, r_val, w_val} = '0;
      r_len = 0; w_len = 0; m_port = 0; m_cd = 0;
    end else begin
      old_rf = m_rf; old_wf = m_wf;
      // a filter follows a run of FL identical registered samples
      if (m_rs == r_val) r_len++; else begin r_val = m_rs; r_len = 1; end
      if (m_ws == w_val) w_len++; else begin w_val = m_ws; w_len = 1; end
      if (r_len >= FL) m_rf = r_val;
      if (w_len >= FL) m_wf = w_val;
      pop = (mq.size() != 0) && req_ready;
      push = 0; set = 0;
      if (!m_active) begin
        if (old_rf && old_wf) begin m_active = 1; set = 1; end
        else if (old_rf || old_wf) begin
          m_active = 1; push = 1;
          e.wr = old_wf; e.port = m_port; e.data = old_wf ? m_cd : 0;
        end
      end else if (!old_rf && !old_wf) m_active = 0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(e); else set = 1;
      end
      if (set) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
      m_rs = in_window(A) && !rd_n;
      m_ws = in_window(A) && !wr_n;
      m_port = int'(A) % (1 << PB);
      m_cd = (in_window(A) && !rd_n) ? int'(rd_data) : (tb_cd_oe ? int'(tb_cd) : 0);
    end
  end

  // compare process: outputs against the model every cycle
  always @(posedge clk) begin
    #1;
    check("req_valid", req_valid, mq.size() != 0);
    check("req_wr",    req_wr,    mq.size() != 0 ? mq[0].wr   : 0);
    check("req_port",  req_port,  mq.size() != 0 ? mq[0].port : 0);
    check("req_data",  req_data,  mq.size() != 0 ? mq[0].data : 0);
    check("overflow",  overflow,  m_ovf);
    check("cs_n",      cs_n,      !(in_window(A) && (!rd_n || !wr_n)));
    if (in_window(A) && !rd_n) check("cd_read", cd, rd_data);
    else if (tb_cd_oe)         check("cd_released", cd, tb_cd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_mode) begin
        req_ready = 1'($urandom % 2);
        ovf_clr   = ($urandom % 16) == 0;
        rd_data   = 8'($urandom);
      end
    end
  endtask

  task automatic access(bit wr, bit rd, logic [7:0] addr, logic [7:0] data, int low, int gap);
    A = addr; tb_cd = data; rd_n = !rd; wr_n = !wr;
    cyc(low);
    rd_n = 1'b1; wr_n = 1'b1;
    cyc(gap);
  endtask

  task automatic pop_one();
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          first;
    logic [7:0]  d42 [5];
    logic [7:0]  a42 [5];
    rst = 1'b1; A = 8'h00; rd_data = 8'h00; tb_cd = 8'h00;
    rd_n = 1'b1; wr_n = 1'b1; req_ready = 1'b0; ovf_clr = 1'b0;
    cyc(3);
    check("rst_valid", req_valid, 0);
    check("rst_ovf",   overflow,  0);
    check("rst_port",  req_port,  0);
    check("rst_cs_n",  cs_n,      1);
    rst = 1'b0;
    cyc(2);

    // write 5A to port 9A, latency from first low-sampling edge
    A = 8'h9A; tb_cd = 8'h5A; wr_n = 1'b0;
    first = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (req_valid && first == 0) first = e;
    end
    @(negedge clk); wr_n = 1'b1;
    check("wr_latency", first, FL + 2);
    check("wr_req_wr",   req_wr,   1);
    check("wr_req_port", req_port, 2);
    check("wr_req_data", req_data, 8'h5A);
    cyc(FL + 2);
    pop_one();
    check("wr_popped", req_valid, 0);

    // read from 99 with rd_data C3
    A = 8'h99; rd_data = 8'hC3; rd_n = 1'b0;
    #1;
    check("rd_cd_drive", cd, 8'hC3);
    check("rd_cs_n", cs_n, 0);
    @(negedge clk);
    cyc(5);
    rd_n = 1'b1;
    cyc(FL + 3);
    check("rd_valid", req_valid, 1);
    check("rd_req_wr",   req_wr,   0);
    check("rd_req_port", req_port, 1);
    check("rd_req_data", req_data, 0);
    pop_one();

    // two-cycle glitch: chip select pulses, nothing queued
    A = 8'h9B; tb_cd = 8'hEE; wr_n = 1'b0;
    #1;
    check("glitch_cs_low", cs_n, 0);
    @(negedge clk);
    cyc(1);
    wr_n = 1'b1;
    #1;
    check("glitch_cs_high", cs_n, 1);
    @(negedge clk);
    cyc(8);
    check("glitch_no_entry", req_valid, 0);

    // five writes without ready: four kept, fifth dropped
    d42 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    a42 = '{8'h98, 8'h99, 8'h9A, 8'h9B, 8'h98};
    for (int i = 0; i < 5; i++) access(1, 0, a42[i], d42[i], 4, 5);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("fifo_order_data", req_data, d42[i]);
      check("fifo_order_port", req_port, i);
      pop_one();
    end
    check("fifo_drained", req_valid, 0);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // full queue with pop and push on the same edge
    for (int i = 0; i < 4; i++) access(1, 0, 8'h98 + 8'(i), 8'hA1 + 8'(i), 4, 5);
    A = 8'h9A; tb_cd = 8'hA5; wr_n = 1'b0;
    cyc(FL + 1);
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
    cyc(1);
    wr_n = 1'b1;
    cyc(5);
    check("fullpop_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check("fullpop_data", req_data, 8'hA2 + 8'(i));
      pop_one();
    end
    check("fullpop_count4", req_valid, 0);

    // reset during an active access
    A = 8'h9B; tb_cd = 8'h77; wr_n = 1'b0;
    cyc(FL + 3);
    check("pre_rst_valid", req_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", req_valid, 0);
    check("midrst_wr",    req_wr,    0);
    check("midrst_data",  req_data,  0);
    check("midrst_ovf",   overflow,  0);
    @(negedge clk);
    cyc(1);
    rst = 1'b0;
    cyc(FL + 3);
    check("post_rst_new_access", req_valid, 1);
    wr_n = 1'b1;
    cyc(FL + 3);
    pop_one();

    // out-of-window access
    A = 8'hA0; tb_cd = 8'h3C; wr_n = 1'b0;
    #1;
    check("a0_cs_n", cs_n, 1);
    check("a0_cd_released", cd, 8'h3C);
    @(negedge clk);
    cyc(5);
    wr_n = 1'b1;
    cyc(6);
    check("a0_no_entry", req_valid, 0);

    // randomized accesses
    rnd_mode = 1;
    for (int n = 0; n < 250; n++) begin
      logic [7:0] addr;
      bit         wr, rd;
      addr = (($urandom % 4) == 0) ? 8'($urandom) : (BASE | 8'($urandom % 4));
      if (($urandom % 10) == 0) begin wr = 1; rd = 1; end
      else begin wr = 1'($urandom % 2); rd = !wr; end
      access(wr, rd, addr, 8'($urandom), $urandom_range(1, 7), $urandom_range(1, 6));
    end
    rnd_mode = 0;
    req_ready = 1'b1; ovf_clr = 1'b0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_io_port_bank.md
CPU_IO_PORT_BANK -- requirements
Module: cpu_io_port_bank

Interface
REQ-001 Parameter BASE_ADDR, default 8'h98: base I/O address of the port window; the low PORT_BITS bits are ignored.
REQ-002 Parameter PORT_BITS, default 2: number of decoded ports is 2**PORT_BITS; legal range 1..4.
REQ-003 Parameter FILTER_LEN, default 3: strobe glitch-filter length in clk samples; legal range 2..8.
REQ-004 Parameter FIFO_DEPTH, default 4: depth of the access queue; must be a power of two, 2..16.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high, as listed in the next two lines.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 A  in  8  CPU address bus.
REQ-009 cd  inout  8  CPU data bus.
REQ-010 rd_iorq_n / wr_iorq_n  in  1 each  CPU read and write I/O strobes, active low.
REQ-011 rd_data  in  8  read data from the core for the currently addressed port.
REQ-012 cs_n  out  1  combinational chip select for bus transceivers, active low.
REQ-013 req_valid / req_ready  out / in  1 each  queue-head handshake to the core.
REQ-014 req_wr  out  1  queue head is a write (1) or a read (0).
REQ-015 req_port  out  PORT_BITS  port index of the queue head.
REQ-016 req_data  out  8  write data of the queue head; 0 for reads.
REQ-017 overflow  out  1  sticky flag: an access was dropped.
REQ-018 ovf_clr  in  1  clears overflow.

Function
REQ-019 Address match SHALL be A[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS].
REQ-020 cs_n SHALL be the combinational NOR of (match & !rd_iorq_n) and (match & !wr_iorq_n).
REQ-021 cd SHALL be driven with rd_data while match & !rd_iorq_n, and SHALL be high-Z otherwise.
REQ-022 Each qualified strobe (match & !strobe_n) SHALL be registered, then filtered: the filtered level changes only after FILTER_LEN consecutive identical registered samples.
REQ-023 A and cd SHALL be registered every cycle; the values used for capture are these registered values.
REQ-024 FSM IDLE -> ACTIVE when exactly one filtered strobe asserts; capture {wr, A[PORT_BITS-1:0], data (writes only)} and push it in the same cycle.
REQ-025 ACTIVE -> IDLE once both filtered strobes are deasserted; no new capture occurs while in ACTIVE.
REQ-026 If both filtered strobes assert in the same cycle in IDLE, the FSM SHALL move to ACTIVE without a push and SHALL set overflow.
REQ-027 Latency: with the queue empty, req_valid SHALL rise exactly FILTER_LEN+2 rising edges after the first edge that samples the strobe low.
REQ-028 Queue: FIFO order is preserved; an entry is popped on a cycle where req_valid & req_ready.
REQ-029 A push when the queue is full and no pop occurs in that cycle SHALL be dropped and SHALL set overflow.
REQ-030 A push when the queue is full with a simultaneous pop SHALL be accepted.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-032 req_port, req_wr and req_data SHALL be stable while req_valid is high and req_ready is low.
REQ-033 overflow clears on ovf_clr; if a set event and ovf_clr occur in the same cycle, set wins.

Reset
REQ-034 Reset SHALL force: FSM to IDLE, filters to deasserted, queue empty, req_valid=0, req_wr=0, req_port=0, req_data=0, overflow=0.
REQ-035 Reset asserted mid-access SHALL discard the access; after reset release a still-low strobe is treated as a new access once filtered.
REQ-036 cs_n and cd SHALL remain combinational and unaffected by reset.

Structure
REQ-037 Package cpu_io_pkg SHALL hold the FSM state enum (IDLE, ACTIVE) and the default parameter constants.
REQ-038 A single sub-module, io_strobe_filter (parameter FILTER_LEN; ports clk, reset, din, dout), SHALL be instantiated once per strobe.

Verification
REQ-039 Write 8'h5A to port 8'h9A, strobe held 6 cycles -> one entry: req_wr=1, req_port=2, req_data=8'h5A, with req_valid at edge FILTER_LEN+2.
REQ-040 Read from 8'h99 with rd_data=8'hC3 -> cd=8'hC3 while the strobe is low; one entry: req_wr=0, req_port=1, req_data=0.
REQ-041 Strobe glitch 2 cycles low (FILTER_LEN=3) -> no entry, and cs_n pulses low.
REQ-042 Five writes with req_ready=0 (FIFO_DEPTH=4) -> four entries kept in order, fifth dropped, overflow=1; ovf_clr -> overflow=0.
REQ-043 Queue full with a pop and a push in the same cycle -> push accepted, occupancy stays 4, overflow=0.
REQ-044 Reset asserted during ACTIVE -> all outputs at reset values and queue empty; access to 8'hA0 -> cs_n=1, cd high-Z, no entry.
